// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, key typedefs, schedule FSM states.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_rkey_t;
    typedef logic [255:0] aes_key256_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused; AES-256 only consumes entries 1..7.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes256_key_step.sv
// One AES-256 key-expansion step: current 256-bit block + round constant index -> next block.
module aes256_key_step
    import aes_pkg::*;
(
    input  aes_key256_t key,
    input  logic [3:0]  rc,
    output aes_key256_t next_key
);

    aes_word_t w [8];
    aes_word_t n [8];

    // Word 0 of the block is the most significant 32 bits.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w[i] = key[255 - 32*i -: 32];
        end
        n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {RCON[rc], 24'h0};
        for (int i = 1; i < 4; i++) begin
            n[i] = w[i] ^ n[i-1];
        end
        n[4] = w[4] ^ sub_word(n[3]);
        for (int i = 5; i < 8; i++) begin
            n[i] = w[i] ^ n[i-1];
        end
        next_key = '0;
        for (int i = 0; i < 8; i++) begin
            next_key[255 - 32*i -: 32] = n[i];
        end
    end

endmodule

// File: rtl/aes256_key_schedule_seq.sv
// Sequential AES-256 key schedule: expands a cipher key into 15 stored round keys.
// Optional macro AES_KEYSCHED_ZEROIZE_EN adds a synchronous zeroize input.
module aes256_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int NRK  = 15,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef AES_KEYSCHED_ZEROIZE_EN
    input  logic            zeroize,
`endif
    input  logic            start,
    input  aes_key256_t     key_in,
    output logic            busy,
    output logic            keys_valid,
    input  logic [IDXW-1:0] rd_idx,
    output aes_rkey_t       rd_key
);

    ks_state_t   state;
    logic [3:0]  rc;
    aes_key256_t work;
    aes_key256_t next_key;
    aes_rkey_t   store [NRK];
    logic        zero_req;

`ifdef AES_KEYSCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    aes256_key_step u_step (
        .key      (work),
        .rc       (rc),
        .next_key (next_key)
    );

    // Step rc produces round keys 2rc and 2rc+1; the final step's lower half is not a round key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            rc         <= '0;
            work       <= '0;
            for (int i = 0; i < NRK; i++) store[i] <= '0;
        end else if (zero_req) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            rc         <= '0;
            work       <= '0;
            for (int i = 0; i < NRK; i++) store[i] <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        work       <= key_in;
                        store[0]   <= key_in[255:128];
                        store[1]   <= key_in[127:0];
                        rc         <= 4'd1;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        state      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    work <= next_key;
                    store[IDXW'({rc[2:0], 1'b0})] <= next_key[255:128];
                    if (rc != 4'd7) begin
                        store[IDXW'({rc[2:0], 1'b1})] <= next_key[127:0];
                        rc <= rc + 4'd1;
                    end else begin
                        rc         <= '0;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read port sees the store contents from before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key <= '0;
        end else if (zero_req) begin
            rd_key <= '0;
        end else if (rd_idx < IDXW'(NRK)) begin
            rd_key <= store[rd_idx];
        end else begin
            rd_key <= '0;
        end
    end

endmodule

// File: tb/tb_aes256_key_schedule_seq.sv
// Self-checking bench for aes256_key_schedule_seq against a word-level FIPS-197 key expansion model.
// Define AES_KEYSCHED_ZEROIZE_EN to also exercise the zeroize port.
module tb_aes256_key_schedule_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_model [256];
    logic [127:0] model_rk   [15];

    aes256_key_schedule_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef AES_KEYSCHED_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // S-box derived from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_model[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWordModel(input logic [31:0] v);
        return {sbox_model[v[31:24]], sbox_model[v[23:16]], sbox_model[v[15:8]], sbox_model[v[7:0]]};
    endfunction

    // Classic 60-word expansion, then grouped into 15 round keys.
    task automatic computeModel(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rcon;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w[i-1];
            if (i % 8 == 0) begin
                rcon = 8'h01;
                for (int j = 1; j < i / 8; j++) rcon = gmul(rcon, 8'h02);
                temp = subWordModel({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
            end else if (i % 8 == 4) begin
                temp = subWordModel(temp);
            end
            w[i] = w[i-8] ^ temp;
        end
        for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge right after the accepting rising edge.
    task automatic applyStimulus(input logic [255:0] key);
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expected_cycles);
        int cnt = 0;
        while (!keys_valid && cnt < 20) begin
            checkOutput({tag, "_busy"}, 128'(busy), 128'd1);
            @(negedge clk);
            cnt++;
        end
        checkOutput({tag, "_latency"}, 128'(cnt), 128'(expected_cycles));
        checkOutput({tag, "_busy_done"}, 128'(busy), 128'd0);
    endtask

    task automatic readKey(input logic [3:0] idx, output logic [127:0] value);
        rd_idx = idx;
        @(negedge clk);
        value = rd_key;
    endtask

    task automatic checkAllKeys(input string tag, input logic use_model);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) begin
            readKey(4'(i), v);
            checkOutput($sformatf("%s_rk%0d", tag, i), v,
                        (use_model && i < 15) ? model_rk[i] : 128'd0);
        end
    endtask

    function automatic logic [255:0] randomKey();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [255:0] fips_key;
    logic [127:0] v;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_idx = '0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        buildSbox();
        fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_valid", 128'(keys_valid), 128'd0);
        checkOutput("reset_rdkey", rd_key, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.3 vector
        computeModel(fips_key);
        applyStimulus(fips_key);
        waitDone("fips", 7);
        checkOutput("fips_valid", 128'(keys_valid), 128'd1);
        readKey(4'd1, v);
        checkOutput("fips_rk1", v, 128'h101112131415161718191a1b1c1d1e1f);
        readKey(4'd2, v);
        checkOutput("fips_rk2", v, 128'ha573c29fa176c498a97fce93a572c09c);
        readKey(4'd14, v);
        checkOutput("fips_rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        checkAllKeys("fips", 1'b1);

        // Start while busy is ignored
        applyStimulus(fips_key);
        repeat (2) @(negedge clk);
        start  = 1'b1;
        key_in = randomKey();
        @(negedge clk);
        start  = 1'b0;
        waitDone("ignore", 4);
        readKey(4'd14, v);
        checkOutput("ignore_rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        checkAllKeys("ignore", 1'b1);

        // Restart from DONE with the all-zero key
        computeModel('0);
        applyStimulus('0);
        checkOutput("restart_valid_drop", 128'(keys_valid), 128'd0);
        waitDone("zero", 7);
        readKey(4'd0, v);
        checkOutput("zero_rk0", v, 128'd0);
        readKey(4'd1, v);
        checkOutput("zero_rk1", v, 128'd0);
        checkAllKeys("zero", 1'b1);

        // Random keys
        for (int t = 0; t < 4; t++) begin
            key_in = randomKey();
            computeModel(key_in);
            applyStimulus(key_in);
            waitDone($sformatf("rand%0d", t), 7);
            checkAllKeys($sformatf("rand%0d", t), 1'b1);
        end

        // Reset mid-expansion
        applyStimulus(randomKey());
        rd_idx = 4'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 128'(busy), 128'd0);
        checkOutput("midrst_valid", 128'(keys_valid), 128'd0);
        checkOutput("midrst_rdkey", rd_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAllKeys("midrst", 1'b0);
        checkOutput("midrst_valid_after", 128'(keys_valid), 128'd0);

`ifdef AES_KEYSCHED_ZEROIZE_EN
        key_in = randomKey();
        computeModel(key_in);
        applyStimulus(key_in);
        waitDone("prezero", 7);
        zeroize = 1'b1;
        start   = 1'b1;
        key_in  = randomKey();
        @(negedge clk);
        zeroize = 1'b0;
        start   = 1'b0;
        checkOutput("zeroize_valid", 128'(keys_valid), 128'd0);
        checkOutput("zeroize_busy", 128'(busy), 128'd0);
        checkOutput("zeroize_rdkey", rd_key, 128'd0);
        @(negedge clk);
        checkOutput("zeroize_idle", 128'(busy), 128'd0);
        checkAllKeys("zeroize", 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes256_key_schedule_seq.md
Name: aes256_key_schedule_seq

Overview:
- Sequential AES-256 key-schedule engine; sits directly downstream of the single-step key expansion logic (256-bit key + 4-bit round constant in, next 256-bit key block out).
- Iterates that step 7 times from a loaded cipher key and stores all 15 128-bit round keys.
- Serves the round keys to the cipher datapath through a registered read port.

Parameters:
- NRK, 15, number of stored 128-bit round keys (fixed for AES-256; not intended to be overridden).
- IDXW, 4, round-key index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to expand key_in; honoured only when busy=0.
- key_in  input  256  cipher key, MSB = first key byte; sampled on an accepted start.
- busy  output  1  expansion in progress.
- keys_valid  output  1  all 15 round keys stored and consistent.
- rd_idx  input  4  round-key index 0..14.
- rd_key  output  128  round key for rd_idx, registered.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; busy=0, keys_valid=0, rd_key=0.
  - Step counter = 0; working key register = 0; key store cleared to 0.
- FSM states: IDLE, EXPAND, DONE.
- Accepting start (IDLE or DONE, start=1):
  - Capture key_in into the working register.
  - Write rk0 = key_in[255:128] and rk1 = key_in[127:0].
  - Set rc=1, busy=1, keys_valid=0; go to EXPAND.
- EXPAND, each cycle (rc = 1..7):
  - Step sub-module computes next = step(work, rc).
  - work <= next.
  - Write rk[2rc] = next[255:128].
  - If rc<7, also write rk[2rc+1] = next[127:0]; the lower half from rc=7 is discarded.
- Leaving EXPAND: after the rc=7 write, go to DONE with busy=0, keys_valid=1.
- Latency: start accepted at edge N; keys_valid=1 after edge N+7.
- Step function (AES-256, words w0..w7 of work, w0 = MSW):
  - n0 = w0 ^ SubWord(RotWord(w7)) ^ {Rcon[rc],24'h0}.
  - n1..n3: n[i] = w[i] ^ n[i-1].
  - n4 = w4 ^ SubWord(n3).
  - n5..n7: n[i] = w[i] ^ n[i-1].
  - Rcon[1..7] = 01,02,04,08,10,20,40.
- start while busy=1: ignored; expansion continues unaffected.
- start in DONE: restarts; keys_valid drops on that same edge.
- Read port:
  - rd_key <= store[rd_idx] on every edge; one-cycle latency; independent of FSM state.
  - rd_idx 15: rd_key <= 0.
  - Reading mid-expansion returns whatever is stored; consumers gate on keys_valid.
  - Read and write of the same index on the same edge returns the old value.
- Reset asserted mid-expansion: immediate return to the reset state; no partial keys are retained as valid.

Optional Feature:
- Macro: AES_KEYSCHED_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - zeroize=1 clears store, work, rd_key, busy and keys_valid to 0 on the next edge and forces IDLE.
  - zeroize overrides start on the same edge.
- Undefined: no zeroize port; key material is cleared only by reset.

Decomposition:
- Shared package aes_pkg:
  - S-box constant array (256x8).
  - Rcon table.
  - Typedefs: aes_word_t (32), aes_rkey_t (128), aes_key256_t (256).
  - FSM state enum.
- One natural sub-module: aes256_key_step (combinational, 256-bit key + 4-bit rc -> 256-bit next block), reusable by the existing expansion stage.

Test Plan:
- FIPS-197 C.3 key 000102...1f, start pulse -> busy for 7 cycles; keys_valid=1 exactly 7 edges after start is accepted.
- Same run, read back:
  - rd_idx=1 -> 101112131415161718191a1b1c1d1e1f.
  - rd_idx=2 -> a573c29fa176c498a97fce93a572c09c.
  - rd_idx=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
- start re-pulsed at cycle 3 of expansion with a different key -> ignored; rd_idx=14 still returns 24fc79cc... after done.
- In DONE, start with key all-zero -> keys_valid drops, then rises; rd_idx=0 and 1 return 0; all 15 entries match a software model.
- rst_n pulsed low mid-expansion -> busy=0, keys_valid=0, rd_key=0 immediately; all indices read 0; rd_idx=15 reads 0.
- With AES_KEYSCHED_ZEROIZE_EN: zeroize asserted in DONE together with start -> all entries read 0, keys_valid=0, state IDLE.
